// File: rtl/prim_stack.sv
// prim_stack: Forth stack engine with T/N in registers and deeper entries in a sync-read RAM.
// Define PRIM_STACK_GUARD_EN to reject ops whose depth precondition fails and flag them on o_err.

module prim_stack #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [3:0]            i_op,
    input  logic [WIDTH-1:0]      i_dat,
    output logic [WIDTH-1:0]      o_t,
    output logic [WIDTH-1:0]      o_n,
    output logic [DEPTH_LOG2+1:0] o_count,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_err,
    input  logic                  i_clr_err
);

    localparam int CW        = DEPTH_LOG2 + 2;
    localparam int RAM_DEPTH = 1 << DEPTH_LOG2;

    localparam logic [CW-1:0]         CAP    = CW'(RAM_DEPTH + 2);
    localparam logic [CW-1:0]         C_ONE  = CW'(1);
    localparam logic [CW-1:0]         C_TWO  = CW'(2);
    localparam logic [CW-1:0]         C_THREE = CW'(3);
    localparam logic [DEPTH_LOG2-1:0] SP_ONE = DEPTH_LOG2'(1);

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_PUSH    = 4'd1;
    localparam logic [3:0] OP_DROP    = 4'd2;
    localparam logic [3:0] OP_DUP     = 4'd3;
    localparam logic [3:0] OP_SWAP    = 4'd4;
    localparam logic [3:0] OP_OVER    = 4'd5;
    localparam logic [3:0] OP_NIP     = 4'd6;
    localparam logic [3:0] OP_ROT     = 4'd7;
    localparam logic [3:0] OP_NROT    = 4'd8;
    localparam logic [3:0] OP_BINOP   = 4'd9;
    localparam logic [3:0] OP_REPLACE = 4'd10;

    typedef enum logic {
        S_IDLE,
        S_RD
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic [WIDTH-1:0]        dat_q, dat_d;
    logic [WIDTH-1:0]        t_q, t_d;
    logic [WIDTH-1:0]        n_q, n_d;
    logic [DEPTH_LOG2-1:0]   sp_q, sp_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    err_q, err_d;
    logic [WIDTH-1:0]        rd_q;

    logic [WIDTH-1:0]        mem [RAM_DEPTH];
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_waddr;
    logic [WIDTH-1:0]        mem_wdata;

    logic                    accept;
    logic                    has2;
    logic                    has3;
    logic                    rd_op;
    logic                    start_rd;
    logic                    guard_fail;
    logic                    exec_en;
    logic [3:0]              exec_op;
    logic [WIDTH-1:0]        exec_dat;
    logic [WIDTH-1:0]        third;

    assign accept = i_valid && o_ready;
    assign has2   = count_q >= C_TWO;
    assign has3   = count_q >= C_THREE;

`ifdef PRIM_STACK_GUARD_EN
    logic has1;
    logic not_full;
    logic pre_ok;

    assign has1     = count_q >= C_ONE;
    assign not_full = count_q < CAP;

    always_comb begin
        pre_ok = 1'b1;
        case (i_op)
            OP_PUSH:    pre_ok = not_full;
            OP_DROP:    pre_ok = has1;
            OP_DUP:     pre_ok = has1 && not_full;
            OP_SWAP:    pre_ok = has2;
            OP_OVER:    pre_ok = has2 && not_full;
            OP_NIP:     pre_ok = has2;
            OP_ROT:     pre_ok = has3;
            OP_NROT:    pre_ok = has3;
            OP_BINOP:   pre_ok = has2;
            OP_REPLACE: pre_ok = has1;
            default:    pre_ok = 1'b1;
        endcase
    end

    assign guard_fail = accept && !pre_ok;
`else
    assign guard_fail = 1'b0;
`endif

    // Ops that consume the third element need a RAM read cycle first
    assign rd_op = (((i_op == OP_DROP) || (i_op == OP_NIP) || (i_op == OP_BINOP)) && has3)
                   || (i_op == OP_ROT) || (i_op == OP_NROT);
    assign start_rd = accept && !guard_fail && rd_op;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_rd) state_d = S_RD;
            S_RD:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == S_IDLE);
    end

    always_comb begin
        t_d       = t_q;
        n_d       = n_q;
        sp_d      = sp_q;
        count_d   = count_q;
        op_d      = op_q;
        dat_d     = dat_q;
        mem_we    = 1'b0;
        mem_waddr = sp_q + SP_ONE;
        mem_wdata = n_q;

        if (state_q == S_RD) begin
            exec_en  = 1'b1;
            exec_op  = op_q;
            exec_dat = dat_q;
            third    = has3 ? rd_q : '0;
        end else begin
            exec_en  = accept && !guard_fail && !rd_op;
            exec_op  = i_op;
            exec_dat = i_dat;
            third    = '0;
        end

        if (start_rd) begin
            op_d  = i_op;
            dat_d = i_dat;
        end

        if (exec_en) begin
            case (exec_op)
                OP_PUSH: begin
                    t_d     = exec_dat;
                    n_d     = t_q;
                    count_d = count_q + C_ONE;
                    if (has2) begin
                        mem_we = 1'b1;
                        sp_d   = sp_q + SP_ONE;
                    end
                end
                OP_DROP: begin
                    t_d     = n_q;
                    n_d     = third;
                    count_d = count_q - C_ONE;
                    if (has3) sp_d = sp_q - SP_ONE;
                end
                OP_DUP: begin
                    n_d     = t_q;
                    count_d = count_q + C_ONE;
                    if (has2) begin
                        mem_we = 1'b1;
                        sp_d   = sp_q + SP_ONE;
                    end
                end
                OP_SWAP: begin
                    t_d = n_q;
                    n_d = t_q;
                end
                OP_OVER: begin
                    t_d     = n_q;
                    n_d     = t_q;
                    count_d = count_q + C_ONE;
                    if (has2) begin
                        mem_we = 1'b1;
                        sp_d   = sp_q + SP_ONE;
                    end
                end
                OP_NIP: begin
                    n_d     = third;
                    count_d = count_q - C_ONE;
                    if (has3) sp_d = sp_q - SP_ONE;
                end
                OP_ROT: begin
                    t_d = third;
                    n_d = t_q;
                    if (has3) begin
                        mem_we    = 1'b1;
                        mem_waddr = sp_q;
                        mem_wdata = n_q;
                    end
                end
                OP_NROT: begin
                    t_d = n_q;
                    n_d = third;
                    if (has3) begin
                        mem_we    = 1'b1;
                        mem_waddr = sp_q;
                        mem_wdata = t_q;
                    end
                end
                OP_BINOP: begin
                    t_d     = exec_dat;
                    n_d     = third;
                    count_d = count_q - C_ONE;
                    if (has3) sp_d = sp_q - SP_ONE;
                end
                OP_REPLACE: begin
                    t_d = exec_dat;
                end
                default: begin
                end
            endcase
        end
    end

    // A fresh error outranks a simultaneous clear
    assign err_d = guard_fail | (err_q & ~i_clr_err);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            t_q     <= '0;
            n_q     <= '0;
            sp_q    <= '1;
            count_q <= '0;
            err_q   <= 1'b0;
            op_q    <= OP_NOP;
            dat_q   <= '0;
        end else begin
            t_q     <= t_d;
            n_q     <= n_d;
            sp_q    <= sp_d;
            count_q <= count_d;
            err_q   <= err_d;
            op_q    <= op_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we && !i_reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (start_rd) begin
            rd_q <= mem[sp_q];
        end
    end

    assign o_t     = t_q;
    assign o_n     = n_q;
    assign o_count = count_q;
    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CAP);
    assign o_err   = err_q;

endmodule
